// File: rtl/xorshift_checker_if.sv
// xorshift_checker_if: sample stream into the checker
interface xorshift_checker_if;
  logic        data_vld;
  logic [63:0] data;
  modport master (output data_vld, data);
  modport slave (input data_vld, data);
endinterface

// File: rtl/xorshift_checker.sv
// xorshift_checker: buffers incoming samples and compares each against the next xorshift64* value
module xorshift_checker #(
  parameter logic [63:0] SEED       = 64'h1,
  parameter logic [31:0] ITERATIONS = 32'd1000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  xorshift_checker_if.slave        in_if,
  output logic [31:0]              match_cnt,
  output logic [31:0]              mismatch_cnt,
  output logic                     error,
  output logic                     overflow,
  output logic [63:0]              exp_data,
  output logic [63:0]              got_data,
  output logic                     busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  if (SEED == 64'd0) begin : g_bad_seed
    $error("SEED must be nonzero");
  end
  if (ITERATIONS == 32'd0) begin : g_bad_iter
    $error("ITERATIONS must be >= 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  typedef enum logic [1:0] {IDLE, STEP, COMPARE} state_t;
  state_t      state, nxt;
  logic [63:0] x, head;
  logic [31:0] it;
  logic [AW:0] wp, rp;
  logic [63:0] mem [FIFO_DEPTH];
  logic        empty, full, pop, push, drop, last;
  function automatic logic [63:0] xs_step(input logic [63:0] v);
    logic [63:0] t;
    t = v ^ (v >> 12);
    t = t ^ (t << 25);
    t = t ^ (t >> 27);
    return t * 64'h5821657736338717;
  endfunction
  // Full when pointers differ only in the wrap bit; a pop in COMPARE frees a slot for a same-cycle push
  always_comb begin
    empty = wp == rp;
    full  = wp == {~rp[AW], rp[AW-1:0]};
    pop   = state == COMPARE;
    push  = in_if.data_vld && (!full || pop);
    drop  = in_if.data_vld && full && !pop;
    last  = it == ITERATIONS - 32'd1;
    head  = mem[rp[AW-1:0]];
    nxt   = state == IDLE ? (empty ? IDLE : STEP) : state == STEP ? (last ? COMPARE : STEP) : IDLE;
  end
  assign busy = state != IDLE || !empty;
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= in_if.data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x            <= SEED;
      it           <= '0;
      wp           <= '0;
      rp           <= '0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      error        <= 1'b0;
      overflow     <= 1'b0;
      exp_data     <= '0;
      got_data     <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE) it <= '0;
      else if (state == STEP) begin
        it <= it + 32'd1;
        x  <= xs_step(x);
      end
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
      if (drop) overflow <= 1'b1;
      if (pop && head == x) match_cnt <= match_cnt + 32'(match_cnt != '1);
      if (pop && head != x) begin
        mismatch_cnt <= mismatch_cnt + 32'(mismatch_cnt != '1);
        error        <= 1'b1;
        if (!error) begin
          exp_data <= x;
          got_data <= head;
        end
      end
    end
  end
endmodule

// File: tb/tb_xorshift_checker.sv
// tb_xorshift_checker: directed checks on two small configurations plus a scoreboarded random stream
module tb_xorshift_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, rst_b, rst_c;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  xorshift_checker_if ifa(), ifb(), ifc();
  logic [31:0] ma, mma, mb, mmb, mc, mmc;
  logic        ea, oa, ba, eb, ob, bb, ec, oc, bc;
  logic [63:0] xa, ga, xb, gb, xc, gc;
  xorshift_checker #(.SEED(64'h1), .ITERATIONS(32'd1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst_a), .in_if(ifa), .match_cnt(ma), .mismatch_cnt(mma), .error(ea),
    .overflow(oa), .exp_data(xa), .got_data(ga), .busy(ba));
  xorshift_checker #(.SEED(64'h1), .ITERATIONS(32'd8), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst_b), .in_if(ifb), .match_cnt(mb), .mismatch_cnt(mmb), .error(eb),
    .overflow(ob), .exp_data(xb), .got_data(gb), .busy(bb));
  xorshift_checker #(.SEED(64'h1234), .ITERATIONS(32'd16), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst_c), .in_if(ifc), .match_cnt(mc), .mismatch_cnt(mmc), .error(ec),
    .overflow(oc), .exp_data(xc), .got_data(gc), .busy(bc));

  // Reference: n xorshift64* steps from the written rules, multiply truncated to 64 bits
  function automatic logic [63:0] xs(input logic [63:0] v, input int n);
    logic [63:0] s;
    s = v;
    for (int i = 0; i < n; i++) begin
      s = s ^ (s >> 12);
      s = s ^ (s << 25);
      s = s ^ (s >> 27);
      s = s * 64'h5821657736338717;
    end
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pulse_a(input logic [63:0] d);
    ifa.data_vld = 1'b1;
    ifa.data = d;
    @(negedge clk);
    ifa.data_vld = 1'b0;
  endtask

  task automatic idle(input int s);
    for (int i = 0; i < 300 && (s != 0 ? bb : ba); i++) @(negedge clk);
    chk($sformatf("idle_%0d", s), s != 0 ? bb : ba, 0);
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
  endtask

  task automatic reset_b();
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  localparam logic [63:0] E1 = 64'h468DCC8564338717;
  logic [63:0] e2, e3, mx;
  int exp_q [$];
  int pm = 0, pmm = 0;

  // Scoreboard monitor: every counter update must match one issued sample at its exact latency
  always @(negedge clk) begin
    if (!rst_c && (mc != pm || mmc != pmm)) begin
      if (exp_q.size() == 0) chk("sb_spurious", 1, 0);
      else begin
        chk("sb_latency", cyc, exp_q.pop_front());
        chk("sb_match_step", mc - pm, 1);
        chk("sb_mismatch_step", mmc - pmm, 0);
      end
      pm = mc;
      pmm = mmc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    e2 = xs(E1, 1);
    e3 = xs(e2, 1);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ifa.data_vld = 1'b1; ifa.data = E1;
    ifb.data_vld = 1'b0; ifb.data = '0;
    ifc.data_vld = 1'b0; ifc.data = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ifa.data_vld = 1'b0;
    chk("rst_match", ma, 0);
    chk("rst_mismatch", mma, 0);
    chk("rst_error", ea, 0);
    chk("rst_overflow", oa, 0);
    chk("rst_exp", xa, 0);
    chk("rst_got", ga, 0);
    chk("rst_busy_vld_ignored", ba, 0);
    fork
      begin
        repeat (6) @(negedge clk);
        chk("rst_vld_ignored_cnt", ma, 0);
        pulse_a(E1);
        @(negedge clk);
        @(negedge clk);
        chk("lat_early", ma, 0);
        @(negedge clk);
        chk("lat_match", ma, 1);
        chk("lat_error", ea, 0);
        chk("lat_busy", ba, 0);
        reset_a();
        pulse_a(64'h0);
        idle(0);
        chk("mm_cnt", mma, 1);
        chk("mm_error", ea, 1);
        chk("mm_exp", xa, E1);
        chk("mm_got", ga, 0);
        chk("mm_match", ma, 0);
        pulse_a(64'h5);
        idle(0);
        chk("mm2_cnt", mma, 2);
        chk("mm2_exp_held", xa, E1);
        chk("mm2_got_held", ga, 0);
        reset_a();
        pulse_a(E1);
        idle(0);
        pulse_a(e2);
        idle(0);
        chk("rs_two_match", ma, 2);
        pulse_a(e3);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("rs_match", ma, 0);
        chk("rs_mismatch", mma, 0);
        chk("rs_error", ea, 0);
        chk("rs_overflow", oa, 0);
        chk("rs_busy", ba, 0);
        repeat (5) @(negedge clk);
        chk("rs_discarded", ma + mma, 0);
        pulse_a(E1);
        idle(0);
        chk("rs_resend_match", ma, 1);
        chk("rs_resend_error", ea, 0);
        reset_b();
        for (int i = 1; i <= 6; i++) begin
          ifb.data_vld = 1'b1;
          ifb.data = xs(64'h1, 8 * i);
          @(negedge clk);
        end
        ifb.data_vld = 1'b0;
        chk("ovf_flag", ob, 1);
        idle(1);
        chk("ovf_total", mb + mmb, 4);
        chk("ovf_match", mb, 4);
        reset_b();
        for (int i = 1; i <= 4; i++) begin
          ifb.data_vld = 1'b1;
          ifb.data = xs(64'h1, 8 * i);
          @(negedge clk);
        end
        ifb.data_vld = 1'b0;
        repeat (6) @(negedge clk);
        ifb.data_vld = 1'b1;
        ifb.data = xs(64'h1, 40);
        @(negedge clk);
        chk("fullpop_overflow", ob, 0);
        chk("fullpop_first", mb, 1);
        ifb.data = xs(64'h1, 48);
        @(negedge clk);
        ifb.data_vld = 1'b0;
        chk("fullpop_still_full", ob, 1);
        idle(1);
        chk("fullpop_match", mb, 5);
        chk("fullpop_mismatch", mmb, 0);
      end
      begin
        mx = 64'h1234;
        for (int i = 0; i < 1000; i++) begin
          mx = xs(mx, 16);
          ifc.data = mx;
          ifc.data_vld = 1'b1;
          @(negedge clk);
          ifc.data_vld = 1'b0;
          exp_q.push_back(cyc + 16 + 2);
          repeat ($urandom_range(18, 26)) @(negedge clk);
        end
        for (int i = 0; i < 100 && bc; i++) @(negedge clk);
      end
    join
    @(negedge clk);
    chk("gold_match", mc, 1000);
    chk("gold_mismatch", mmc, 0);
    chk("gold_overflow", oc, 0);
    chk("gold_error", ec, 0);
    chk("gold_queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/xorshift_checker.md
XORSHIFT_CHECKER -- requirements
Module: xorshift_checker

Interface
REQ-001 Parameter SEED, 64-bit, default 64'h1, start state of the expected xorshift64* sequence; it SHALL be nonzero.
REQ-002 Parameter ITERATIONS, 32-bit, default 1000000, number of xorshift64* steps per expected sample; it SHALL be >= 1, and 0 SHALL be an elaboration error.
REQ-003 Parameter FIFO_DEPTH, integer, default 4, input sample buffer depth; it SHALL be a power of 2 and >= 2.
REQ-004 clk  input  1  sole clock, all logic on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 data_vld  input  1  one sample per cycle in which it is high.
REQ-007 data  input  64  sample value, qualified by data_vld.
REQ-008 match_cnt  output  32  number of samples equal to the expected value.
REQ-009 mismatch_cnt  output  32  number of samples differing from the expected value.
REQ-010 error  output  1  sticky, set on the first mismatch.
REQ-011 overflow  output  1  sticky, set when a sample is dropped because the FIFO is full.
REQ-012 exp_data  output  64  expected value captured at the first mismatch.
REQ-013 got_data  output  64  received value captured at the first mismatch.
REQ-014 busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-015 One xorshift64* step SHALL be: x^=x>>12; x^=x<<25; x^=x>>27; x=x*64'h5821657736338717. The multiply SHALL be truncated mod 2^64.
REQ-016 Expected state x SHALL hold SEED after reset. The Nth expected value SHALL be x after N*ITERATIONS steps.
REQ-017 Pushing into the FIFO:
- A data_vld=1 cycle with FIFO not full SHALL push data.
- A data_vld=1 cycle with FIFO full and no pop in the same cycle SHALL drop the sample, set overflow, and leave both counters unchanged.
REQ-018 A simultaneous push and pop on a full FIFO SHALL accept the push with no overflow.
REQ-019 The FSM SHALL have states IDLE, STEP and COMPARE:
- IDLE -> STEP when the FIFO is non-empty, clearing the iteration counter.
- STEP performs one step per cycle and goes to COMPARE after exactly ITERATIONS cycles.
- COMPARE lasts one cycle, pops the FIFO head, then goes to IDLE.
REQ-020 In COMPARE, the popped head SHALL be compared with x:
- equal -> match_cnt increments;
- unequal -> mismatch_cnt increments and error is set;
- if error was previously clear, exp_data and got_data SHALL capture x and the head.
REQ-021 Counters SHALL saturate at 32'hFFFFFFFF.
REQ-022 Latency: a sample with data_vld high in cycle c into an empty FIFO with the FSM in IDLE SHALL have its counter update visible in cycle c+ITERATIONS+3.
REQ-023 Sustained throughput SHALL be one sample per ITERATIONS+2 cycles.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Occupancy SHALL be tracked with one extra pointer bit so full and empty are distinguishable.
REQ-025 exp_data and got_data SHALL remain unchanged after the first mismatch until reset.

Reset
REQ-026 While rst is high, on each posedge:
- state = IDLE, x = SEED, iteration counter = 0, FIFO empty;
- match_cnt = 0, mismatch_cnt = 0, error = 0, overflow = 0, exp_data = 0, got_data = 0, busy = 0.
REQ-027 data_vld SHALL be ignored in any cycle in which rst is high.
REQ-028 Reset asserted mid-STEP or mid-COMPARE SHALL abort the operation, discard buffered samples, and restart the sequence from SEED.

Verification
REQ-029 SEED=1, ITERATIONS=1, one data_vld pulse in cycle c with data=64'h468DCC8564338717 -> match_cnt=1 in cycle c+4; error=0; busy=0 in cycle c+4.
REQ-030 SEED=1, ITERATIONS=1, one data_vld pulse with data=0 -> mismatch_cnt=1, error=1, exp_data=64'h468DCC8564338717, got_data=0.
REQ-031 ITERATIONS=8, FIFO_DEPTH=4, data_vld high for 6 consecutive cycles starting in cycle c -> samples from cycles c+4 and c+5 dropped, overflow=1, match_cnt+mismatch_cnt=4 once busy=0.
REQ-032 FIFO full and FSM in COMPARE, data_vld=1 in that cycle -> push accepted, overflow stays 0, FIFO stays full.
REQ-033 Two correct samples followed by rst pulsed during STEP of the third sample, then the first correct sample resent -> after reset all outputs are 0; after the resend match_cnt=1 and error=0.
REQ-034 Golden model: a random-gap stream of correct values (SEED=64'h1234, ITERATIONS=16, 1000 samples, gaps >= 18 cycles) -> match_cnt=1000, mismatch_cnt=0, overflow=0.
